// File: rtl/core_if_stage_pf.sv
// Instruction-fetch stage with a prefetch FIFO, multiple outstanding fetches,
// decode backpressure and branch redirect with stale-response discard.
module core_if_stage_pf #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h4000_0000),
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] pc_branch_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_instr_o,
    output logic            busy_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_q, fetch_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [XLEN-1:0]  last_instr_q, last_pc_q;
    logic [XLEN-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q    [FIFO_DEPTH];

    logic            valid_c, req_c, grant_c, push_c, pop_c, drop_c;
    logic [XLEN-1:0] target_c;

    // A request needs a free outstanding slot and a FIFO credit for its response.
    assign valid_c  = (count_q != '0);
    assign req_c    = rst_ni && !branch_taken_i
                      && (outst_q < CNT_W'(MAX_OUTST))
                      && ((SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(FIFO_DEPTH));
    assign grant_c  = req_c && instr_gnt_i;
    assign drop_c   = instr_rvalid_i && (discard_q != '0);
    assign push_c   = instr_rvalid_i && !branch_taken_i && (discard_q == '0);
    assign pop_c    = valid_c && instr_ready_i && !branch_taken_i;
    assign target_c = pc_branch_i & ~XLEN'(3);

    always_comb begin
        fetch_d   = fetch_q;
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        discard_d = discard_q;
        outst_d   = outst_q + CNT_W'(grant_c) - CNT_W'(instr_rvalid_i);
        if (branch_taken_i) begin
            // Everything still in flight becomes stale, except a response landing now.
            fetch_d   = target_c;
            resp_pc_d = target_c;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            discard_d = outst_q - CNT_W'(instr_rvalid_i);
        end else begin
            if (grant_c) fetch_d = fetch_q + XLEN'(4);
            if (push_c) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (drop_c) discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_q      <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            fetch_q   <= fetch_d;
            resp_pc_q <= resp_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            // Remember the shown head so the outputs stay put once the FIFO drains.
            if (valid_c) begin
                last_instr_q <= fifo_instr_q[rd_ptr_q];
                last_pc_q    <= fifo_pc_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_c) begin
            fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(push_c && count_q == CNT_W'(FIFO_DEPTH)));
    end

    assign instr_req_o   = req_c;
    assign instr_addr_o  = fetch_q;
    assign instr_valid_o = valid_c;
    assign instr_o       = valid_c ? fifo_instr_q[rd_ptr_q] : last_instr_q;
    assign pc_instr_o    = valid_c ? fifo_pc_q[rd_ptr_q]    : last_pc_q;
    assign busy_o        = (outst_q != '0) || (discard_q != '0);

endmodule

// File: tb/tb_core_if_stage_pf.sv
// Bench for core_if_stage_pf: queue-based fetch model plus in-order memory model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_core_if_stage_pf;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] pc_branch_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_instr_o;
    logic        busy_o;

    core_if_stage_pf dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .branch_taken_i (branch_taken_i),
        .pc_branch_i    (pc_branch_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .pc_instr_o     (pc_instr_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;
    typedef struct { logic [31:0] a; int due; } mreq_t;

    // Stimulus knobs
    logic        rst_drv = 1'b0, br = 1'b0, rdy = 1'b0, gnt_en = 1'b0;
    logic [31:0] br_tgt = '0;
    int          lat = 1;

    // Model state
    ent_t        m_fifo[$];
    mreq_t       memq[$];
    logic [31:0] m_fetch, m_resp, m_last_i, m_last_pc;
    int          m_stale = 0;
    bit          m_ok = 0;
    int          cyc = 0, grants = 0;
    int          ncmp = 0, nfail = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_all(input logic ereq);
        logic        ev;
        logic [31:0] ei, ep;
        ev = (m_fifo.size() != 0);
        ei = ev ? m_fifo[0].d  : m_last_i;
        ep = ev ? m_fifo[0].pc : m_last_pc;
        chk("req",   32'(instr_req_o),   32'(ereq));
        chk("addr",  instr_addr_o,       m_fetch);
        chk("valid", 32'(instr_valid_o), 32'(ev));
        chk("instr", instr_o,            ei);
        chk("pc",    pc_instr_o,         ep);
        chk("busy",  32'(busy_o),        32'((memq.size() != 0) || (m_stale != 0)));
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic step();
        logic        rv, ereq, grant, pop;
        logic [31:0] rd;
        @(negedge clk);
        rv = rst_drv && (memq.size() > 0) && (memq[0].due <= cyc);
        rd = rv ? mem_data(memq[0].a) : 32'h0;
        rst_ni         = rst_drv;
        branch_taken_i = br;
        pc_branch_i    = br_tgt;
        instr_ready_i  = rdy;
        instr_gnt_i    = gnt_en;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        ereq = rst_drv && !br && (memq.size() < MAXO) && (m_fifo.size() + memq.size() < DEPTH);
        #1;
        if (m_ok) compare_all(ereq);
        grant = ereq && gnt_en;
        pop   = (m_fifo.size() > 0) && rdy;
        @(posedge clk);
        if (!rst_drv) begin
            m_fetch = RPC; m_resp = RPC; m_stale = 0;
            m_fifo.delete(); memq.delete();
            m_last_i = '0; m_last_pc = '0;
            m_ok = 1;
        end else begin
            if (m_fifo.size() > 0) begin
                m_last_i  = m_fifo[0].d;
                m_last_pc = m_fifo[0].pc;
            end
            if (br) begin
                m_stale = memq.size() - (rv ? 1 : 0);
                m_fifo.delete();
                m_fetch = {br_tgt[31:2], 2'b00};
                m_resp  = m_fetch;
                if (rv) void'(memq.pop_front());
            end else begin
                if (pop) void'(m_fifo.pop_front());
                if (rv) begin
                    void'(memq.pop_front());
                    if (m_stale > 0) m_stale--;
                    else begin
                        m_fifo.push_back('{pc: m_resp, d: rd});
                        m_resp += 32'd4;
                    end
                end
                if (grant) begin
                    memq.push_back('{a: m_fetch, due: cyc + lat});
                    m_fetch += 32'd4;
                    grants++;
                end
            end
        end
        cyc++;
    endtask

    task automatic wait_valid(input string nm);
        bit found = 0;
        for (int i = 0; i < 30; i++) begin
            step(); #2;
            if (instr_valid_o) begin found = 1; break; end
        end
        if (!found) begin
            ncmp++; nfail++;
            $display("FAIL %s: instr_valid_o never rose within 30 cycles", nm);
        end
    endtask

    task automatic do_reset();
        rst_drv = 1'b0; br = 1'b0;
        step();
        rst_drv = 1'b1;
    endtask

    initial begin
        logic [31:0] gp, rp;
        bit          found;

        // Power-on reset and zero-wait memory streaming
        rst_drv = 1'b0;
        repeat (3) step();
        #2;
        chk("rst_addr",  instr_addr_o,       RPC);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o),        32'd0);
        chk("rst_instr", instr_o,            32'd0);
        chk("rst_pc",    pc_instr_o,         32'd0);
        rst_drv = 1'b1; gnt_en = 1'b1; lat = 1; rdy = 1'b1;
        step(); #2;
        chk("t1_addr1", instr_addr_o, 32'h4000_0004);
        step(); #2;
        chk("t1_valid", 32'(instr_valid_o), 32'd1);
        chk("t1_pc0",   pc_instr_o,         32'h4000_0000);
        chk("t1_ins0",  instr_o,            32'h9EAD_BEEF);
        step(); #2;
        chk("t1_pc1",   pc_instr_o,         32'h4000_0004);
        repeat (10) step();

        // Decode stalled from reset: FIFO fills to exactly four entries
        do_reset();
        rdy = 1'b0; grants = 0;
        repeat (8) step();
        #2;
        chk("t2_grants", 32'(grants),        32'd4);
        chk("t2_valid",  32'(instr_valid_o), 32'd1);
        chk("t2_head",   pc_instr_o,         32'h4000_0000);
        chk("t2_busy",   32'(busy_o),        32'd0);
        rdy = 1'b1;
        step(); #2;
        chk("t2_next",   pc_instr_o,         32'h4000_0004);
        repeat (6) step();

        // Slow memory: outstanding limit caps grants
        do_reset();
        lat = 5; grants = 0;
        repeat (5) step();
        #2;
        chk("t3_grants", 32'(grants), 32'd2);
        chk("t3_busy",   32'(busy_o), 32'd1);
        repeat (10) step();

        // Redirect with two requests in flight
        do_reset();
        lat = 3;
        repeat (2) step();
        br = 1'b1; br_tgt = 32'h4000_0102;
        step();
        br = 1'b0; #2;
        chk("t4_addr",  instr_addr_o,       32'h4000_0100);
        chk("t4_valid", 32'(instr_valid_o), 32'd0);
        chk("t4_busy",  32'(busy_o),        32'd1);
        wait_valid("t4_wait");
        chk("t4_pc",    pc_instr_o,         32'h4000_0100);
        chk("t4_ins",   instr_o,            32'h9EAD_BFEF);
        repeat (4) step();

        // Redirect coinciding with a response and a pop
        do_reset();
        lat = 3; rdy = 1'b0; found = 0;
        for (int i = 0; i < 20; i++) begin
            if (memq.size() == 2 && memq[0].due <= cyc && m_fifo.size() > 0) begin
                found = 1; break;
            end
            step();
        end
        if (!found) begin
            ncmp++; nfail++;
            $display("FAIL t5_setup: no rvalid/pop/branch cycle found");
        end
        rdy = 1'b1; br = 1'b1; br_tgt = 32'h4000_0203;
        step();
        br = 1'b0; gnt_en = 1'b0; #2;
        chk("t5_valid", 32'(instr_valid_o), 32'd0);
        chk("t5_busy",  32'(busy_o),        32'd1);
        repeat (4) step();
        #2;
        chk("t5_idle",  32'(busy_o),        32'd0);
        chk("t5_none",  32'(instr_valid_o), 32'd0);
        gnt_en = 1'b1;
        wait_valid("t5_wait");
        chk("t5_pc",    pc_instr_o,         32'h4000_0200);

        // Reset mid-stream with the FIFO half full
        lat = 1; rdy = 1'b0; found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_fifo.size() == 2) begin found = 1; break; end
            step();
        end
        if (!found) begin
            ncmp++; nfail++;
            $display("FAIL t6_setup: FIFO never held two entries");
        end
        do_reset();
        #2;
        chk("t6_valid", 32'(instr_valid_o), 32'd0);
        chk("t6_busy",  32'(busy_o),        32'd0);
        chk("t6_addr",  instr_addr_o,       RPC);
        rdy = 1'b1;
        wait_valid("t6_wait");
        chk("t6_pc",    pc_instr_o,         RPC);

        // Irregular grant and ready patterns
        gp = 32'hB6D5_3A7F; rp = 32'h5C3E_91A6; lat = 2;
        for (int i = 0; i < 32; i++) begin
            gnt_en = gp[i];
            rdy    = rp[i];
            step();
        end
        rdy = 1'b1; gnt_en = 1'b1;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
